// File: rtl/full_adder_pkg.sv
// Shared constants for the full_adder block: default counter width and saturation limit helper.
package full_adder_pkg;

  localparam int unsigned CNT_W_DEFAULT = 8;

  // All-ones value for a counter of the given width (valid for widths up to 31).
  function automatic int unsigned sat_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam int unsigned CNT_MAX_DEFAULT = sat_max(CNT_W_DEFAULT);

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder: s = a ^ b, c = a & b.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/full_adder.sv
// Full adder built from two half adders, with registered outputs, a saturating carry counter
// and an optional sticky self-check enabled by the FULL_ADDER_CHECK_EN macro.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i0,
  input  logic             i1,
  input  logic             cin,
  output logic             sum,
  output logic             cout,
  output logic             sum_q,
  output logic             cout_q,
  output logic [CNT_W-1:0] carry_cnt,
  output logic             err
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(sat_max(CNT_W));

  logic w_s1;
  logic w_c1;
  logic w_s2;
  logic w_c2;

  half_adder u_ha0 (
    .a (i0),
    .b (i1),
    .s (w_s1),
    .c (w_c1)
  );

  half_adder u_ha1 (
    .a (w_s1),
    .b (cin),
    .s (w_s2),
    .c (w_c2)
  );

  assign sum  = w_s2;
  assign cout = w_c1 | w_c2;

  logic             r_sum_q;
  logic             r_cout_q;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum_q  <= 1'b0;
      r_cout_q <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sum_q  <= sum;
      r_cout_q <= cout;
      if (cout && (r_cnt != CntMax)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign sum_q     = r_sum_q;
  assign cout_q    = r_cout_q;
  assign carry_cnt = r_cnt;

`ifdef FULL_ADDER_CHECK_EN
  // Behavioral reference, independent of the half-adder structure.
  logic [1:0] w_ref;
  logic       r_err;

  assign w_ref = {1'b0, i0} + {1'b0, i1} + {1'b0, cin};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_ref != {cout, sum}) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder: default-width and 3-bit counter instances share stimulus.
module tb_full_adder;

`ifdef FULL_ADDER_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i0  = 1'b0;
  logic i1  = 1'b0;
  logic cin = 1'b0;

  logic       sum8, cout8, sumq8, coutq8, err8;
  logic [7:0] cnt8;
  logic       sum3, cout3, sumq3, coutq3, err3;
  logic [2:0] cnt3;

  always #5 clk = ~clk;

  full_adder dut8 (
    .clk       (clk),
    .rst       (rst),
    .i0        (i0),
    .i1        (i1),
    .cin       (cin),
    .sum       (sum8),
    .cout      (cout8),
    .sum_q     (sumq8),
    .cout_q    (coutq8),
    .carry_cnt (cnt8),
    .err       (err8)
  );

  full_adder #(
    .CNT_W (3)
  ) dut3 (
    .clk       (clk),
    .rst       (rst),
    .i0        (i0),
    .i1        (i1),
    .cin       (cin),
    .sum       (sum3),
    .cout      (cout3),
    .sum_q     (sumq3),
    .cout_q    (coutq3),
    .carry_cnt (cnt3),
    .err       (err3)
  );

  typedef struct packed {
    logic       sum_q;
    logic       cout_q;
    logic [7:0] cnt8;
    logic [2:0] cnt3;
    logic       err;
  } reg_exp_t;

  reg_exp_t   exp_q[$];
  logic [1:0] comb_q[$];
  reg_exp_t   m;
  bit         fault = 1'b0;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {cout,sum}; with the injected fault only the first half-adder carry survives.
  function automatic logic [1:0] comb_model(input logic a, input logic b, input logic c);
    logic [1:0] t;
    t = {1'b0, a} + {1'b0, b} + {1'b0, c};
    if (fault) t[1] = a & b;
    return t;
  endfunction

  task automatic drive_comb(input logic a, input logic b, input logic c, input logic [1:0] e_in);
    logic [1:0] e;
    i0 = a;
    i1 = b;
    cin = c;
    comb_q.push_back(e_in);
    #1;
    e = comb_q.pop_front();
    check_eq("comb8", {30'd0, cout8, sum8}, {30'd0, e});
    check_eq("comb3", {30'd0, cout3, sum3}, {30'd0, e});
  endtask

  task automatic step(input logic a, input logic b, input logic c, input logic r);
    logic [1:0] fa;
    logic [1:0] tru;
    reg_exp_t   e;
    @(negedge clk);
    rst = r;
    fa  = comb_model(a, b, c);
    tru = {1'b0, a} + {1'b0, b} + {1'b0, c};
    drive_comb(a, b, c, fa);
    if (r) begin
      m = '0;
    end else begin
      m.sum_q  = fa[0];
      m.cout_q = fa[1];
      if (fa[1] && m.cnt8 != 8'd255) m.cnt8 = m.cnt8 + 8'd1;
      if (fa[1] && m.cnt3 != 3'd7) m.cnt3 = m.cnt3 + 3'd1;
      if (ChkEn && fa != tru) m.err = 1'b1;
    end
    exp_q.push_back(m);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("sum_q8", {31'd0, sumq8}, {31'd0, e.sum_q});
    check_eq("cout_q8", {31'd0, coutq8}, {31'd0, e.cout_q});
    check_eq("cnt8", {24'd0, cnt8}, {24'd0, e.cnt8});
    check_eq("err8", {31'd0, err8}, {31'd0, e.err});
    check_eq("sum_q3", {31'd0, sumq3}, {31'd0, e.sum_q});
    check_eq("cout_q3", {31'd0, coutq3}, {31'd0, e.cout_q});
    check_eq("cnt3", {29'd0, cnt3}, {29'd0, e.cnt3});
    check_eq("err3", {31'd0, err3}, {31'd0, e.err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] tbl [8];
    logic [2:0] v;
    tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    m = '0;

    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Exhaustive combinational sweep, held in reset so registers stay cleared.
    for (int k = 0; k < 8; k++) begin
      v = 3'(k);
      drive_comb(v[2], v[1], v[0], tbl[k]);
      #29;
    end

    // Registered capture: prior values held, then 1+1+0 lands on the next edge.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);

    // Count to 5, reset mid-count, resume.
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("cnt_at_5", {24'd0, cnt8}, 32'd5);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);

    // Saturation of the 3-bit counter.
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("cnt3_sat", {29'd0, cnt3}, 32'd7);

    for (int k = 0; k < 8; k++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 5) == 0));
    end

    // Fault injection on the second half-adder carry.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    force dut8.w_c2 = 1'b0;
    force dut3.w_c2 = 1'b0;
    fault = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    release dut8.w_c2;
    release dut3.w_c2;
    fault = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
